pwm_ramp_sequencer: RTL and testbench

Control block that sequences the shared PWM peripheral. It accepts a ramp request carrying a channel mask, a target duty, a step size and a step interval. It turns on the enable registers for the masked channels, then steps the global pwm_duty_cycle toward the target at a fixed rate and reports completion. Its outputs drive the en_reg_* and pwm_duty_cycle inputs of pwm_peripheral in the top-level tt_um wrapper.

---
 rtl/pwm_ramp_sequencer_if.sv | 37 +++
 rtl/pwm_ramp_sequencer.sv | 157 +++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// ============================================================================
// Module   : pwm_ramp_sequencer_if
// Brief    : Ramp request handshake between a requester and pwm_ramp_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_ramp_sequencer_if #(
  parameter int INTERVAL_W = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [15:0]           cfg_mask;
  logic [7:0]            cfg_target;
  logic [7:0]            cfg_step;
  logic [INTERVAL_W-1:0] cfg_interval;

  modport master (
    output cfg_valid,
    output cfg_mask,
    output cfg_target,
    output cfg_step,
    output cfg_interval,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mask,
    input  cfg_target,
    input  cfg_step,
    input  cfg_interval,
    output cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
// ============================================================================
// Module   : pwm_ramp_sequencer
// Brief    : Enables masked PWM channels, then steps the global duty toward a
//            target at a fixed rate. Optional macro: PWM_RAMP_AUTODISABLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_sequencer #(
  parameter int INTERVAL_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pwm_ramp_sequencer_if.slave   cfg,
  input  wire logic             abort,
  output logic [7:0]            en_reg_out_7_0,
  output logic [7:0]            en_reg_out_15_8,
  output logic [7:0]            en_reg_pwm_7_0,
  output logic [7:0]            en_reg_pwm_15_8,
  output logic [7:0]            pwm_duty_cycle,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [7:0]            r_target;
  logic [7:0]            r_step;
  logic [INTERVAL_W-1:0] r_interval;
  logic [INTERVAL_W-1:0] r_cnt;
  logic [15:0]           r_en_out;
  logic [15:0]           r_en_pwm;
  logic [7:0]            r_duty;
  logic                  r_busy;
  logic                  r_done;

  logic [8:0]            w_up;
  logic [8:0]            w_dn;
  logic [7:0]            w_next_duty;
  logic [7:0]            w_step_in;
  logic [15:0]           w_done_en_out;
  logic [15:0]           w_done_en_pwm;

  // 9-bit sum/difference so the clamp to target also catches 0x00/0xFF wrap.
  always_comb begin
    w_up        = {1'b0, r_duty} + {1'b0, r_step};
    w_dn        = {1'b0, r_duty} - {1'b0, r_step};
    w_next_duty = r_target;
    if (r_duty < r_target) begin
      if (w_up < {1'b0, r_target}) begin
        w_next_duty = w_up[7:0];
      end
    end else if (!w_dn[8] && (w_dn[7:0] > r_target)) begin
      w_next_duty = w_dn[7:0];
    end
  end

  assign w_step_in = (cfg.cfg_step == 8'd0) ? 8'd1 : cfg.cfg_step;

`ifdef PWM_RAMP_AUTODISABLE_EN
  logic [15:0] r_mask;

  // A completed ramp down to zero releases the channels it was asked to drive.
  always_comb begin
    w_done_en_out = r_en_out;
    w_done_en_pwm = r_en_pwm;
    if (r_target == 8'd0) begin
      w_done_en_out = r_en_out & ~r_mask;
      w_done_en_pwm = r_en_pwm & ~r_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= 16'h0000;
    end else if ((r_state == S_IDLE) && cfg.cfg_valid) begin
      r_mask <= cfg.cfg_mask;
    end
  end
`else
  assign w_done_en_out = r_en_out;
  assign w_done_en_pwm = r_en_pwm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_target   <= 8'h00;
      r_step     <= 8'h00;
      r_interval <= '0;
      r_cnt      <= '0;
      r_en_out   <= 16'h0000;
      r_en_pwm   <= 16'h0000;
      r_duty     <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg.cfg_valid) begin
            r_target   <= cfg.cfg_target;
            r_step     <= w_step_in;
            r_interval <= cfg.cfg_interval;
            r_cnt      <= cfg.cfg_interval;
            r_en_out   <= r_en_out | cfg.cfg_mask;
            r_en_pwm   <= r_en_pwm | cfg.cfg_mask;
            r_busy     <= 1'b1;
            r_state    <= S_RAMP;
          end
        end
        S_RAMP: begin
          // Abort outranks both completion and a step due this cycle.
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_duty == r_target) begin
            r_done   <= 1'b1;
            r_en_out <= w_done_en_out;
            r_en_pwm <= w_done_en_pwm;
            r_state  <= S_DONE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_duty <= w_next_duty;
            r_cnt  <= r_interval;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg.cfg_ready     = (r_state == S_IDLE);
  assign en_reg_out_7_0    = r_en_out[7:0];
  assign en_reg_out_15_8   = r_en_out[15:8];
  assign en_reg_pwm_7_0    = r_en_pwm[7:0];
  assign en_reg_pwm_15_8   = r_en_pwm[15:8];
  assign pwm_duty_cycle    = r_duty;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
// ============================================================================
// Module   : tb_pwm_ramp_sequencer
// Brief    : Directed bench for pwm_ramp_sequencer with a timeline-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_sequencer;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       busy, done;

  int n_vec = 0;
  int n_err = 0;

  pwm_ramp_sequencer_if #(.INTERVAL_W(16)) cfg_if ();

  pwm_ramp_sequencer #(.INTERVAL_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg             (cfg_if.slave),
    .abort           (abort),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance the whole future of the ramp is written out as one
  // entry per cycle; idle cycles just hold the last values.
  typedef struct {
    logic [7:0]  duty;
    logic        dn;
    logic [15:0] en;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_duty;
  logic [15:0] m_en;

  function automatic int next_duty(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    return (d - s < t) ? t : d - s;
  endfunction

  function automatic void build(input int d, input int t, input int s0,
                                input int iv, input logic [15:0] en, input logic [15:0] mask);
    int s;
    ent_t e;
    s      = (s0 == 0) ? 1 : s0;
    e.dn   = 1'b0;
    e.en   = en;
    e.duty = 8'(d);
    q.push_back(e);
    while (d != t) begin
      for (int k = 0; k < iv; k++) q.push_back(e);
      d      = next_duty(d, t, s);
      e.duty = 8'(d);
      q.push_back(e);
    end
    e.dn = 1'b1;
`ifdef PWM_RAMP_AUTODISABLE_EN
    if (t == 0) e.en = en & ~mask;
`else
    if (mask === 16'hxxxx) e.en = en;
`endif
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_duty = 8'h00;
      m_en   = 16'h0000;
      chk("rst_duty", {24'h0, pwm_duty_cycle}, 32'h0);
      chk("rst_en", {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0}, 32'h0);
      chk("rst_flags", {busy, done, cfg_if.cfg_ready}, 32'h1);
    end else begin
      if (q.size() > 0) begin
        e = q[0];
        chk("m_ready", {31'h0, cfg_if.cfg_ready}, 32'h0);
        chk("m_busy", {31'h0, busy}, 32'h1);
        chk("m_done", {31'h0, done}, {31'h0, e.dn});
      end else begin
        e.duty = m_duty;
        e.en   = m_en;
        e.dn   = 1'b0;
        chk("m_ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
        chk("m_busy", {31'h0, busy}, 32'h0);
        chk("m_done", {31'h0, done}, 32'h0);
      end
      chk("m_duty", {24'h0, pwm_duty_cycle}, {24'h0, e.duty});
      chk("m_en_out", {16'h0, en_reg_out_15_8, en_reg_out_7_0}, {16'h0, e.en});
      chk("m_en_pwm", {16'h0, en_reg_pwm_15_8, en_reg_pwm_7_0}, {16'h0, e.en});
      if (q.size() > 0) begin
        e = q.pop_front();
        m_duty = e.duty;
        m_en   = e.en;
        if (abort && !e.dn) q.delete();
      end else if (cfg_if.cfg_valid) begin
        build(int'(m_duty), int'(cfg_if.cfg_target), int'(cfg_if.cfg_step),
              int'(cfg_if.cfg_interval), m_en | cfg_if.cfg_mask, cfg_if.cfg_mask);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cfg_if.cfg_ready && k < 300) begin
      tick(1);
      k++;
    end
    if (!cfg_if.cfg_ready) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  // Returns in cycle N+1 where N is the acceptance cycle.
  task automatic request(input logic [15:0] mask, input logic [7:0] t,
                         input logic [7:0] s, input logic [15:0] iv);
    wait_ready();
    cfg_if.cfg_mask     = mask;
    cfg_if.cfg_target   = t;
    cfg_if.cfg_step     = s;
    cfg_if.cfg_interval = iv;
    cfg_if.cfg_valid    = 1'b1;
    tick(1);
    cfg_if.cfg_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_mask     = 16'h0;
    cfg_if.cfg_target   = 8'h0;
    cfg_if.cfg_step     = 8'h0;
    cfg_if.cfg_interval = 16'h0;
    tick(3);
    #2 rst_n = 1'b1;
    tick(1);
    chk("reset_ready", {31'h0, cfg_if.cfg_ready}, 32'h1);
    chk("reset_duty", {24'h0, pwm_duty_cycle}, 32'h0);

    // Ramp 0x00 -> 0x40, step 0x10, interval 3
    request(16'h00FF, 8'h40, 8'h10, 16'd3);
    chk("t1_en_lo", {16'h0, en_reg_out_7_0, en_reg_pwm_7_0}, 32'hFFFF);
    chk("t1_en_hi", {16'h0, en_reg_out_15_8, en_reg_pwm_15_8}, 32'h0);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    tick(4);  chk("t1_n5", {24'h0, pwm_duty_cycle}, 32'h10);
    tick(4);  chk("t1_n9", {24'h0, pwm_duty_cycle}, 32'h20);
    tick(4);  chk("t1_n13", {24'h0, pwm_duty_cycle}, 32'h30);
    tick(4);  chk("t1_n17", {24'h0, pwm_duty_cycle, 7'h0, done}, 32'h4000);
    tick(1);  chk("t1_n18_done", {31'h0, done}, 32'h1);
    tick(1);  chk("t1_n19", {30'h0, done, cfg_if.cfg_ready}, 32'h1);

    // No overshoot going up
    request(16'h0000, 8'h45, 8'h10, 16'd0);
    chk("t2_n1", {24'h0, pwm_duty_cycle}, 32'h40);
    tick(1);  chk("t2_n2", {24'h0, pwm_duty_cycle}, 32'h45);
    tick(1);  chk("t2_n3_done", {31'h0, done}, 32'h1);

    // Target equals current duty: done at N+2, enables OR'd
    request(16'hFF00, 8'h45, 8'h10, 16'd5);
    chk("t3_en_hi", {16'h0, en_reg_out_15_8, en_reg_pwm_15_8}, 32'hFFFF);
    chk("t3_n1_done", {31'h0, done}, 32'h0);
    tick(1);  chk("t3_n2", {23'h0, done, pwm_duty_cycle}, 32'h145);

    // No wrap going down
    request(16'h0000, 8'h00, 8'h30, 16'd0);
    tick(1);  chk("t4_n2", {24'h0, pwm_duty_cycle}, 32'h15);
    tick(1);  chk("t4_n3", {24'h0, pwm_duty_cycle}, 32'h00);
    tick(1);  chk("t4_n4_done", {31'h0, done}, 32'h1);

    // Abort on the cycle a step is due; ignored cfg_valid while busy
    request(16'h0000, 8'h80, 8'h10, 16'd2);
    tick(2);
    cfg_if.cfg_target = 8'h11;
    cfg_if.cfg_valid  = 1'b1;
    tick(1);
    cfg_if.cfg_valid  = 1'b0;
    chk("t5_n4", {24'h0, pwm_duty_cycle}, 32'h10);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_abort_duty", {24'h0, pwm_duty_cycle}, 32'h20);
    chk("t5_abort_flags", {busy, done, cfg_if.cfg_ready}, 32'h1);
    tick(3);
    chk("t5_hold", {23'h0, done, pwm_duty_cycle}, 32'h20);

    // Asynchronous reset mid-ramp
    request(16'h0001, 8'hFF, 8'h01, 16'd0);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_duty", {24'h0, pwm_duty_cycle}, 32'h0);
    chk("t6_async_en", {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0}, 32'h0);
    chk("t6_async_flags", {busy, done, cfg_if.cfg_ready}, 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(2);
    chk("t6_post", {busy, done, cfg_if.cfg_ready}, 32'h1);
    chk("t6_post_duty", {24'h0, pwm_duty_cycle}, 32'h0);

    // Auto-disable on a completed ramp to zero
    request(16'hFFFF, 8'h20, 8'h10, 16'd0);
    request(16'h0F0F, 8'h00, 8'h10, 16'd0);
    tick(3);
    chk("t7_done", {31'h0, done}, 32'h1);
`ifdef PWM_RAMP_AUTODISABLE_EN
    chk("t7_en", {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0}, 32'hF0F0F0F0);
`else
    chk("t7_en", {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0}, 32'hFFFFFFFF);
`endif

    // step of zero behaves as one
    request(16'h0000, 8'h02, 8'h00, 16'd0);
    tick(1);  chk("t8_n2", {24'h0, pwm_duty_cycle}, 32'h01);
    tick(1);  chk("t8_n3", {24'h0, pwm_duty_cycle}, 32'h02);
    wait_ready();
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
